pwm_sample_decoder: RTL and testbench
=====================================

PWM_SAMPLE_DECODER -- requirements
Module: pwm_sample_decoder

Interface
REQ-001 Parameter: FRAME_BITS, default 8, log2 of PWM frame length in clk cycles; sample width equals FRAME_BITS.
REQ-002 Parameter: FIFO_DEPTH, default 2, number of output sample entries; power of two, at least 2.
REQ-003 Port list, one clock; reset is synchronous and active-high:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  PWM bitstream, synchronous to clk (loopback of a pwm_audio output).
- pwm_sample_decoder__output_s  output  FRAME_BITS  decoded PCM sample, FIFO head.
- pwm_sample_decoder__output_s_vld  output  1  FIFO non-empty.
- pwm_sample_decoder__output_s_rdy  input  1  consumer ready.
- overflow  output  1  sticky: a decoded sample was dropped.
- frame_strobe  output  1  one-cycle pulse on the cycle a frame's result is registered.

Function
REQ-004 A free-running FRAME_BITS-bit frame counter shall start at 0 after reset, increment every cycle and wrap from 2^FRAME_BITS-1 to 0.
REQ-005 A (FRAME_BITS+1)-bit accumulator shall add pwm_in every cycle; it restarts from the current cycle's pwm_in on the cycle after the counter wraps.
REQ-006 On the cycle the counter equals 2^FRAME_BITS-1, the frame result shall be accumulator plus that cycle's pwm_in.
- Result saturates to 2^FRAME_BITS-1 when all 2^FRAME_BITS cycles are high (256 -> 255).
REQ-007 The frame result shall be pushed into the FIFO at the next rising edge, with frame_strobe high for exactly the following cycle.
REQ-008 Latency: output_s_vld shall rise the cycle after the push (an empty FIFO shows the sample 1 cycle after the frame's last input cycle).
REQ-009 Handshake: a transfer occurs when output_s_vld and output_s_rdy are both high at a rising edge.
- output_s and output_s_vld shall stay stable while vld is high and rdy is low.
REQ-010 FIFO ordering shall be strict first-in first-out. vld shall equal non-empty.
REQ-011 Push and pop in the same cycle on a full FIFO shall both succeed with no drop. Occupancy stays full.
REQ-012 A push into a full FIFO with no simultaneous pop shall drop the new sample, keep the stored contents, and set overflow.
REQ-013 overflow shall stay set until reset. No other input clears it.
REQ-014 output_s shall be 0 while the FIFO is empty.
REQ-015 output_s_rdy shall never stall the counter or the accumulator; decoding is continuous.

Reset
REQ-016 While reset is high at a rising edge, these shall return to their reset values, and the accumulator shall also be 0:
- counter 0, FIFO empty
- output_s 0, output_s_vld 0
- overflow 0, frame_strobe 0
REQ-017 Reset mid-frame shall discard the partial accumulation. The first frame after reset deasserts starts on the cycle reset is first sampled low.
REQ-018 Reset shall take priority over a simultaneous push or pop.

Structure
REQ-019 The shared package shall hold:
- the FRAME_BITS default and the FIFO_DEPTH default
- the sample typedef (FRAME_BITS wide)
- the saturation constant (all ones)
These shall be shared with pwm_audio and the bytebeat top level.
REQ-020 The FIFO shall be one sub-module, sample_fifo: parameterised width and depth, valid/ready pop side, push side with full flag.
REQ-021 The frame counter and the accumulator shall live in pwm_sample_decoder itself; no further sub-modules.

Verification
REQ-022 Each bench scenario below shall be run with the default parameters.
- pwm_in tied 0, rdy=1 for 3 frames -> three samples of 0x00; vld high 1 cycle after each frame end, at cycles 257, 513, 769 after reset release.
- pwm_in high for the first 0x80 cycles of each frame, loopback from pwm_audio with sample=0x80 and common reset -> every decoded sample is 0x80.
- pwm_in tied 1 -> samples saturate to 0xFF; overflow stays 0 with rdy=1.
- rdy=0 for 4 frames with inputs 0x10, 0x20, 0x30, 0x40 -> FIFO holds 0x10, 0x20; overflow set at the third frame end; then rdy=1 -> pops 0x10, 0x20 only.
- FIFO full and rdy=1 exactly on the push cycle -> no drop, overflow remains 0, order preserved.
- reset asserted at counter=100 mid-frame with pwm_in=1 -> vld=0, overflow=0; the next sample counts only cycles after release (a full high frame gives 0xFF, not a carried-over value).

Source files
------------

// File: rtl/pwm_sample_decoder_pkg.sv
// pwm_sample_decoder_pkg: shared defaults, sample type and saturation constant for the PWM audio path.
package pwm_sample_decoder_pkg;
  localparam int FRAME_BITS_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 2;
  typedef logic [FRAME_BITS_DEF-1:0] sample_t;
  localparam sample_t SAMPLE_SAT = '1;
endpackage

// File: rtl/pwm_sample_decoder_if.sv
// pwm_sample_decoder_if: valid/ready sample stream between the decoder FIFO and its consumer.
interface pwm_sample_decoder_if #(parameter int W = pwm_sample_decoder_pkg::FRAME_BITS_DEF) ();
  logic [W-1:0] data;
  logic vld;
  logic rdy;
  modport master (output data, output vld, input rdy);
  modport slave (input data, input vld, output rdy);
endinterface

// File: rtl/pwm_sample_decoder_sample_fifo.sv
// sample_fifo: power-of-two FIFO with a push/full side and a valid/ready pop side; head reads 0 when empty.
module sample_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         full_o,
  pwm_sample_decoder_if.master pop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok, push_ok;
  always_comb begin
    full_o = cnt_q == FULL_CNT;
    pop.vld = cnt_q != '0;
    pop.data = pop.vld ? mem_q[rd_q] : '0;
    pop_ok = pop.vld & pop.rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = push_i & (~full_o | pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= push_data_i;
endmodule

// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: counts high cycles per 2^FRAME_BITS-cycle PWM frame and queues each saturated count as a PCM sample.
module pwm_sample_decoder
  import pwm_sample_decoder_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [FRAME_BITS-1:0] pwm_sample_decoder__output_s,
  output logic                  pwm_sample_decoder__output_s_vld,
  input  logic                  pwm_sample_decoder__output_s_rdy,
  output logic                  overflow,
  output logic                  frame_strobe
);
  logic [FRAME_BITS-1:0] cnt_q, res_q, res_d;
  logic [FRAME_BITS:0] acc_q, acc_d;
  logic push_q, ovf_q, last, full, drop;
  pwm_sample_decoder_if #(.W(FRAME_BITS)) s_if ();
  always_comb begin
    last = &cnt_q;
    acc_d = (cnt_q == '0 ? '0 : acc_q) + (FRAME_BITS+1)'(pwm_in);
    res_d = acc_d[FRAME_BITS] ? '1 : acc_d[FRAME_BITS-1:0];
    drop = push_q & full & ~(s_if.vld & s_if.rdy);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      push_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_d;
      push_q <= last;
      if (last) res_q <= res_d;
      ovf_q <= ovf_q | drop;
    end
  end
  sample_fifo #(.W(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push_i     (push_q),
    .push_data_i(res_q),
    .full_o     (full),
    .pop        (s_if.master)
  );
  assign s_if.rdy = pwm_sample_decoder__output_s_rdy;
  assign pwm_sample_decoder__output_s = s_if.data;
  assign pwm_sample_decoder__output_s_vld = s_if.vld;
  assign overflow = ovf_q;
  assign frame_strobe = push_q;
endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb_pwm_sample_decoder: randomized frames checked every cycle against a frame-sum/queue reference model.
module tb_pwm_sample_decoder;
  import pwm_sample_decoder_pkg::*;
  localparam int FLEN = 1 << FRAME_BITS_DEF;
  logic clk = 1'b0, reset = 1'b1, pwm_in = 1'b0, overflow, frame_strobe;
  pwm_sample_decoder_if #(.W(FRAME_BITS_DEF)) s_if ();
  always #5 clk = ~clk;
  pwm_sample_decoder dut (
    .clk                             (clk),
    .reset                           (reset),
    .pwm_in                          (pwm_in),
    .pwm_sample_decoder__output_s    (s_if.data),
    .pwm_sample_decoder__output_s_vld(s_if.vld),
    .pwm_sample_decoder__output_s_rdy(s_if.rdy),
    .overflow                        (overflow),
    .frame_strobe                    (frame_strobe)
  );
  int checks = 0, passed = 0;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  // Reference model: k counts edges since reset release; each frame is a plain sum of its bits.
  int k = 0, fsum = 0, s = 0, pend_val = 0;
  bit pend = 0, ovf_m = 0, strb_m = 0, live = 0;
  sample_t q[$];
  always @(posedge clk) begin
    if (reset) begin
      k = 0; fsum = 0; pend = 0; ovf_m = 0; strb_m = 0; live = 1; q.delete();
    end else begin
      s = fsum + int'(pwm_in);
      if (q.size() > 0 && s_if.rdy) void'(q.pop_front());
      if (pend) begin
        if (q.size() < FIFO_DEPTH_DEF) q.push_back(sample_t'(pend_val));
        else ovf_m = 1;
      end
      strb_m = (k % FLEN) == FLEN - 1;
      pend = strb_m;
      pend_val = s > FLEN - 1 ? FLEN - 1 : s;
      fsum = strb_m ? 0 : s;
      k++;
    end
  end
  always @(negedge clk) if (live) begin
    check("vld", 32'(s_if.vld), 32'(q.size() > 0));
    check("data", 32'(s_if.data), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("strobe", 32'(frame_strobe), 32'(strb_m));
  end
  int pmode = 0, duty = 0, rmode = 1;
  int dt[4];
  function automatic logic pwm_of(int kk);
    int d;
    d = pmode == 0 ? duty : dt[(kk / FLEN) % 4];
    return pmode == 2 ? logic'($urandom_range(1)) : logic'((kk % FLEN) < d);
  endfunction
  function automatic logic rdy_of(int kk);
    return rmode == 2 ? logic'($urandom_range(1)) : rmode == 3 ? logic'(kk == 3 * FLEN) : logic'(rmode);
  endfunction
  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pwm_in = pwm_of(k);
      s_if.rdy = rdy_of(k);
    end
  endtask
  task automatic restart();
    reset = 1'b1;
    run(3);
    reset = 1'b0;
  endtask
  sample_t popped[$];
  always @(posedge clk) if (!reset && s_if.vld && s_if.rdy) popped.push_back(s_if.data);
  int lat;
  initial begin
    s_if.rdy = 1'b1;
    pmode = 0; duty = 0; rmode = 1;
    run(2);
    check("rst_vld", 32'(s_if.vld), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    restart();
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      run(1);
      if (s_if.vld) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'd257);
    run(3 * FLEN);
    duty = 'h80; rmode = 2;
    restart();
    run(3 * FLEN + 10);
    duty = FLEN; rmode = 1;
    restart();
    run(3 * FLEN + 10);
    check("sat_no_ovf", 32'(overflow), 32'd0);
    pmode = 1; rmode = 0;
    dt = '{'h10, 'h20, 'h30, 'h40};
    restart();
    run(4 * FLEN + 4);
    check("ovf_set", 32'(overflow), 32'd1);
    popped.delete();
    rmode = 1;
    run(8);
    check("pop_cnt", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      check("pop0", 32'(popped[0]), 32'h10);
      check("pop1", 32'(popped[1]), 32'h20);
    end
    dt = '{'h11, 'h22, 'h33, 'h44};
    rmode = 3;
    restart();
    popped.delete();
    run(3 * FLEN + 2);
    rmode = 1;
    run(8);
    check("full_pop_ovf", 32'(overflow), 32'd0);
    check("full_pop_cnt", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      check("fp0", 32'(popped[0]), 32'h11);
      check("fp1", 32'(popped[1]), 32'h22);
      check("fp2", 32'(popped[2]), 32'h33);
    end
    pmode = 0; duty = FLEN; rmode = 1;
    restart();
    for (int i = 0; i < FLEN && k % FLEN != 100; i++) run(1);
    reset = 1'b1;
    run(2);
    check("mid_rst_vld", 32'(s_if.vld), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    run(FLEN + 1);
    check("mid_rst_sample", 32'(s_if.data), 32'hFF);
    run(FLEN);
    pmode = 2; rmode = 2;
    restart();
    run(4 * FLEN);
    pmode = 1;
    for (int i = 0; i < 4; i++) dt[i] = $urandom_range(FLEN);
    restart();
    run(6 * FLEN);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
